updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//  Parametrised successor to the fixed 4-bit up counter in the FSMs collection.
//  Modulo-N up/down counter with per-cycle enable, synchronous clear, parallel load,
//  wrap or saturate mode, terminal-count/wrap pulse and sticky overflow flag.
//  Used as a timer/event counter inside FSM datapaths and as a bench DUT.
// PARAMETERS
//  WIDTH        4               counter width in bits (>=2)
//  MAX_COUNT    2**WIDTH-1      highest count value (modulus = MAX_COUNT+1), 1..2**WIDTH-1
//  PRESCALE     4               advance every PRESCALE enabled cycles (PRESCALE_EN only, >=2)
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-low reset
//  clr       in   1      synchronous clear: count<=0, ovf<=0, prescaler<=0
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  load value; values >MAX_COUNT clamp to MAX_COUNT
//  en        in   1      count enable (advance when high)
//  up        in   1      direction: 1 up, 0 down
//  sat_mode  in   1      0 wrap at bounds, 1 saturate at bounds
//  count     out  WIDTH  current count (registered)
//  tc        out  1      combinational: (up && count==MAX_COUNT) || (!up && count==0)
//  wrap      out  1      registered 1-cycle pulse: previous edge wrapped or hit saturation
//  ovf       out  1      sticky: set on any wrap or saturation event; cleared by clr only
// BEHAVIOUR
//  - Reset (reset==0, async): count=0, wrap=0, ovf=0, prescaler=0; tc reflects count.
//  - Priority per edge: clr > load > advance > hold.
//  - advance = en && tick (tick=1 when PRESCALE_EN undefined). Latency: count changes
//    on the edge where advance is sampled; no pipeline.
//  - Up, count<MAX_COUNT: count+1. Up, count==MAX_COUNT: wrap mode -> 0; sat mode -> hold.
//  - Down, count>0: count-1. Down, count==0: wrap mode -> MAX_COUNT; sat mode -> hold.
//  - Boundary event (advance && tc): wrap<=1 for one cycle, ovf<=1; else wrap<=0.
//  - Non-power-of-2 MAX_COUNT: arithmetic never passes MAX_COUNT; compare, not carry.
//  - load: count<=min(load_val,MAX_COUNT); wrap<=0; ovf unchanged; prescaler unchanged.
//  - clr with load/en: clr wins; wrap<=0.
//  - up/sat_mode may change any cycle; sampled on the same edge as en.
//  - Reset mid-count: immediate return to reset values; counting resumes from 0
//    on the first edge after release with en high.
// CONFIGURATION
//  - `PRESCALE_EN defined: internal prescaler counts en-high cycles 0..PRESCALE-1;
//    tick=1 only when prescaler==PRESCALE-1 (prescaler then returns to 0). Counter
//    advances once per PRESCALE enabled cycles; en low freezes prescaler.
//  - `PRESCALE_EN undefined: no prescaler logic; tick tied 1; PRESCALE ignored.
// STRUCTURE
//  - counter_pkg: mode constants (MODE_WRAP=0, MODE_SAT=1), DIR_UP/DIR_DOWN,
//    clamp function for load values.
//  - Sub-module count_prescaler (instantiated only under `PRESCALE_EN):
//    clk, reset, clr, en -> tick.
//  - Top holds count/wrap/ovf registers and next-state logic in one always block.
// TESTING (WIDTH=4, MAX_COUNT=9 unless stated)
//  1. Reset low mid-count at count=6 -> count=0, wrap=0, ovf=0 same cycle (async).
//  2. en=1, up=1, wrap mode, 12 edges from 0 -> 1..9,0,1,2; wrap pulse after 10th edge; ovf=1.
//  3. up=0, sat mode from 0 -> count holds 0, tc=1, wrap pulses each edge, ovf=1.
//  4. load=1, load_val=14 -> count=9; load with clr same edge -> count=0, ovf=0.
//  5. MAX_COUNT=15 (default), down wrap from 0 -> 15, wrap=1 next cycle.
//  6. `PRESCALE_EN, PRESCALE=4, en=1 for 12 edges -> count 0->3, advances on edges 4,8,12.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter family.
package counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;

   // Load values above the modulus are pinned to the top count.
   function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
      return (val > max) ? max : val;
   endfunction

endpackage

// File: rtl/count_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the last cycle of each group.
module count_prescaler
   import counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-(MAX_COUNT+1) up/down counter with clear, load, wrap/saturate mode,
// wrap pulse and sticky overflow. Optional prescaler under `PRESCALE_EN.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MAX_COUNT = 2**WIDTH - 1,
   parameter int unsigned PRESCALE  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic             tick;
   logic             advance;

`ifdef PRESCALE_EN
   // Load leaves the prescaler untouched, so it only sees non-load enabled cycles.
   count_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (en && !load),
      .tick  (tick)
   );
`else
   assign tick = 1'b1;
`endif

   assign advance = en && tick;
   assign tc      = ((up == DIR_UP) && (count_q == MAXV)) ||
                    ((up == DIR_DOWN) && (count_q == '0));

   // Bounds are detected by compare so non-power-of-2 moduli never overshoot.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      ovf_d   = ovf_q;
      if (clr) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (load) begin
         count_d = WIDTH'(clamp_load(32'(load_val), 32'(MAX_COUNT)));
      end else if (advance) begin
         if (tc) begin
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
            if (sat_mode == MODE_WRAP)
               count_d = (up == DIR_UP) ? '0 : MAXV;
         end else begin
            count_d = (up == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: DUT a is mod-10, DUT b uses the default mod-16; both share stimulus.
module tb_updown_mod_counter;

   logic       clk = 1'b0;
   logic       reset, clr, load, en, up, sat_mode;
   logic [3:0] load_val;
   logic [3:0] count_a, count_b;
   logic       tc_a, tc_b, wrap_a, wrap_b, ovf_a, ovf_b;

   int total = 0;
   int fails = 0;

   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(4)) dut_a (
      .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .sat_mode(sat_mode),
      .count(count_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
   );

   updown_mod_counter #(.WIDTH(4)) dut_b (
      .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up(up), .sat_mode(sat_mode),
      .count(count_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
      en = 1'b0; up = 1'b0; sat_mode = 1'b0;
      #2;
      chk("reset_count", count_a, 0);
      chk("reset_wrap", wrap_a, 0);
      chk("reset_ovf", ovf_a, 0);
      chk("reset_tc_down", tc_a, 1);
      edge_step();
      reset = 1'b1;

`ifdef PRESCALE_EN
      en = 1'b1; up = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         edge_step();
         chk($sformatf("pre_count_e%0d", k), count_a, k / 4);
      end
      en = 1'b0;
      for (int k = 0; k < 5; k++) edge_step();
      chk("pre_freeze", count_a, 3);
      en = 1'b1;
      for (int k = 0; k < 3; k++) edge_step();
      chk("pre_3_of_4", count_a, 3);
      edge_step();
      chk("pre_4_of_4", count_a, 4);
`else
      // up count, wrap mode, through the modulus
      en = 1'b1; up = 1'b1; sat_mode = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         edge_step();
         chk($sformatf("up_count_e%0d", k), count_a, k % 10);
         chk($sformatf("up_wrap_e%0d", k), wrap_a, (k == 10) ? 1 : 0);
         chk($sformatf("up_ovf_e%0d", k), ovf_a, (k >= 10) ? 1 : 0);
         if (k == 9) chk("up_tc_at_max", tc_a, 1);
         if (k == 8) chk("up_tc_below_max", tc_a, 0);
      end

      // async reset mid-count
      for (int k = 0; k < 4; k++) edge_step();
      chk("pre_reset_count", count_a, 6);
      #2 reset = 1'b0;
      #1;
      chk("async_count", count_a, 0);
      chk("async_wrap", wrap_a, 0);
      chk("async_ovf", ovf_a, 0);
      edge_step();
      chk("held_reset_count", count_a, 0);
      reset = 1'b1;
      edge_step();
      chk("resume_count", count_a, 1);

      // saturate down at zero
      clr = 1'b1; en = 1'b0;
      edge_step();
      chk("clr_count", count_a, 0);
      clr = 1'b0; up = 1'b0; sat_mode = 1'b1; en = 1'b1;
      #1;
      chk("sat_tc_zero", tc_a, 1);
      for (int k = 1; k <= 3; k++) begin
         edge_step();
         chk($sformatf("sat_dn_count_e%0d", k), count_a, 0);
         chk($sformatf("sat_dn_wrap_e%0d", k), wrap_a, 1);
         chk($sformatf("sat_dn_ovf_e%0d", k), ovf_a, 1);
      end

      // clamped load, then load colliding with clear
      load = 1'b1; load_val = 4'd14; en = 1'b1; up = 1'b1;
      edge_step();
      chk("load_clamp", count_a, 9);
      chk("load_wrap", wrap_a, 0);
      chk("load_ovf_kept", ovf_a, 1);
      chk("load_b_14", count_b, 14);
      clr = 1'b1;
      edge_step();
      chk("load_clr_count", count_a, 0);
      chk("load_clr_ovf", ovf_a, 0);
      clr = 1'b0;

      // saturate up at max
      load_val = 4'd9;
      edge_step();
      load = 1'b0;
      edge_step();
      chk("sat_up_hold", count_a, 9);
      chk("sat_up_wrap", wrap_a, 1);

      // down count, then down wrap from zero on both moduli
      load = 1'b1; load_val = 4'd5; sat_mode = 1'b0;
      edge_step();
      load = 1'b0; up = 1'b0;
      edge_step();
      chk("down_5_to_4", count_a, 4);
      chk("down_wrap_low", wrap_a, 0);
      clr = 1'b1;
      edge_step();
      clr = 1'b0;
      edge_step();
      chk("down_wrap_a", count_a, 9);
      chk("down_wrap_a_pulse", wrap_a, 1);
      chk("down_wrap_b", count_b, 15);
      chk("down_wrap_b_pulse", wrap_b, 1);
      chk("down_wrap_b_ovf", ovf_b, 1);
      en = 1'b0;
      edge_step();
      chk("idle_wrap_b", wrap_b, 0);
      chk("idle_hold_b", count_b, 15);
      chk("idle_tc_b_down", tc_b, 0);
`endif

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
